// File: rtl/axi_burst_wr_if.sv
// Stream input and AXI4 write-channel bundle for axi_burst_wr.
// The burst writer takes the master view; memory/stream models take the slave view.
interface axi_burst_wr_if #(
    parameter int DW = 64,
    parameter int AW = 32
) ();
    localparam int SW = DW / 8;

    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;

    logic [AW-1:0] m_awaddr;
    logic [7:0]    m_awlen;
    logic [2:0]    m_awsize;
    logic [1:0]    m_awburst;
    logic          m_awvalid;
    logic          m_awready;

    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic          m_wlast;
    logic          m_wvalid;
    logic          m_wready;

    logic [1:0]    m_bresp;
    logic          m_bvalid;
    logic          m_bready;

    modport master (
        input  s_data, s_valid,
        output s_ready,
        output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        input  m_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  m_wready,
        input  m_bresp, m_bvalid,
        output m_bready
    );

    modport slave (
        output s_data, s_valid,
        input  s_ready,
        input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        output m_awready,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid,
        output m_wready,
        output m_bresp, m_bvalid,
        input  m_bready
    );
endinterface

// File: rtl/axi_burst_wr.sv
// Stream-to-memory write DMA: buffers a pixel-word stream and writes it
// out as AXI4 INCR bursts, issuing each AW only once its data is buffered.
module axi_burst_wr #(
    parameter int DW         = 64,
    parameter int AW         = 32,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int CW         = 24
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [CW-1:0] total_beats,
    output logic          busy,
    output logic          done,
    output logic          err,
    axi_burst_wr_if.master bus
);
    localparam int SW = DW / 8;
    localparam int SZ = $clog2(SW);
    localparam int FA = $clog2(FIFO_DEPTH);
    localparam int FC = FA + 1;

    typedef enum logic [1:0] {IDLE, AREQ, WDATA, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] total_q, total_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [CW-1:0] bi_q, bi_d;
    logic [CW-1:0] bd_q, bd_d;
    logic [7:0]    beat_q, beat_d;
    logic          awvalid_q, awvalid_d;
    logic          err_q, err_d;
    logic          zdone_q, zdone_d;

    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [FA-1:0] wp_q, wp_d;
    logic [FA-1:0] rp_q, rp_d;
    logic [FC-1:0] cnt_q, cnt_d;

    logic          full, empty, push, pop, bhs;
    logic          wvalid, wlast;
    logic [7:0]    cur_len;
    logic [CW-1:0] len_beats;
    logic [FC-1:0] len_fifo;

    // Length field of the burst currently being requested or written.
    always_comb begin
        cur_len = 8'd0;
        if (rem_q >= CW'(BURST_LEN)) begin
            cur_len = 8'(BURST_LEN - 1);
        end else if (rem_q != '0) begin
            cur_len = 8'(rem_q - 1'b1);
        end
    end

    assign len_beats = CW'(cur_len) + 1'b1;
    assign len_fifo  = FC'(cur_len) + 1'b1;

    assign busy   = (state_q != IDLE);
    assign full   = (cnt_q == FC'(FIFO_DEPTH));
    assign empty  = (cnt_q == '0);
    assign push   = bus.s_valid && bus.s_ready;
    assign wvalid = (state_q == WDATA) && !empty;
    assign wlast  = wvalid && (beat_q == cur_len);
    assign pop    = wvalid && bus.m_wready;
    assign bhs    = bus.m_bvalid && busy;

    assign bus.s_ready   = busy && !full && (in_cnt_q < total_q);
    assign bus.m_awaddr  = addr_q;
    assign bus.m_awlen   = busy ? cur_len : 8'd0;
    assign bus.m_awsize  = 3'(SZ);
    assign bus.m_awburst = 2'b01;
    assign bus.m_awvalid = awvalid_q;
    assign bus.m_wdata   = wvalid ? mem_q[rp_q] : '0;
    assign bus.m_wstrb   = '1;
    assign bus.m_wlast   = wlast;
    assign bus.m_wvalid  = wvalid;
    assign bus.m_bready  = busy;

    assign done = zdone_q || ((state_q == DRAIN) && (bd_q == bi_q));
    assign err  = err_q;

    // Input FIFO pointer and occupancy update.
    always_comb begin
        wp_d  = push ? wp_q + 1'b1 : wp_q;
        rp_d  = pop ? rp_q + 1'b1 : rp_q;
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= bus.s_data;
        end
    end

    // Transfer sequencing, burst bookkeeping and B-response tracking.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        total_d   = total_q;
        in_cnt_d  = in_cnt_q;
        rem_d     = rem_q;
        bi_d      = bi_q;
        bd_d      = bd_q;
        beat_d    = beat_q;
        awvalid_d = awvalid_q;
        err_d     = err_q;
        zdone_d   = (state_q == IDLE) && start && (total_beats == '0);
        if (push) begin
            in_cnt_d = in_cnt_q + 1'b1;
        end
        if (bhs) begin
            bd_d = bd_q + 1'b1;
            if (bus.m_bresp != 2'b00) begin
                err_d = 1'b1;
            end
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (total_beats != '0) begin
                        state_d  = AREQ;
                        addr_d   = base_addr;
                        total_d  = total_beats;
                        rem_d    = total_beats;
                        in_cnt_d = '0;
                        bi_d     = '0;
                        bd_d     = '0;
                        beat_d   = '0;
                    end
                end
            end
            AREQ: begin
                if (awvalid_q) begin
                    if (bus.m_awready) begin
                        awvalid_d = 1'b0;
                        bi_d      = bi_q + 1'b1;
                        state_d   = WDATA;
                    end
                end else if (cnt_q >= len_fifo) begin
                    awvalid_d = 1'b1;
                end
            end
            WDATA: begin
                if (pop) begin
                    if (wlast) begin
                        beat_d  = '0;
                        addr_d  = addr_q + (AW'(len_beats) << SZ);
                        rem_d   = rem_q - len_beats;
                        state_d = (rem_q == len_beats) ? DRAIN : AREQ;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (bd_q == bi_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any transfer and flushes the FIFO.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            total_q   <= '0;
            in_cnt_q  <= '0;
            rem_q     <= '0;
            bi_q      <= '0;
            bd_q      <= '0;
            beat_q    <= '0;
            awvalid_q <= 1'b0;
            err_q     <= 1'b0;
            zdone_q   <= 1'b0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            total_q   <= total_d;
            in_cnt_q  <= in_cnt_d;
            rem_q     <= rem_d;
            bi_q      <= bi_d;
            bd_q      <= bd_d;
            beat_q    <= beat_d;
            awvalid_q <= awvalid_d;
            err_q     <= err_d;
            zdone_q   <= zdone_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_axi_burst_wr.sv
// Bench for axi_burst_wr: random stream source, AXI slave with memory
// model, and per-transfer checks against expected bursts and data.
module tb_axi_burst_wr;
    logic        clk;
    logic        rstn;
    logic        start;
    logic [31:0] base_addr;
    logic [23:0] total_beats;
    logic        busy, done, err;

    axi_burst_wr_if #(.DW(64), .AW(32)) bus ();

    axi_burst_wr dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .base_addr   (base_addr),
        .total_beats (total_beats),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .bus         (bus)
    );

    int checks = 0;
    int errors = 0;

    int p_sv = 100, p_aw = 100, p_w = 100, p_b = 100;
    int err_b_idx = -1;

    int cyc = 0;
    int acc_total = 0, w_total = 0, b_issue = 0, b_pending = 0;
    int done_cnt = 0, done_cyc = -1, last_b_cyc = -2;
    int awv_cycles = 0, busy_cycles = 0, lvl = 0;
    int w_burst = 0, w_beat = 0;
    logic        aw_stall = 0;
    logic [31:0] st_addr;
    logic [7:0]  st_len;
    logic        ack_s = 0, ack_b = 0;

    logic [39:0] aw_log[$];
    logic [63:0] gen_q[$];
    logic [63:0] mem [logic [31:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream source, AXI slave and bus monitor, one iteration per cycle.
    initial begin : bfm
        logic [39:0] e;
        logic [31:0] a;
        logic [63:0] wd;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        bus.m_bvalid  = 1'b0;
        bus.m_bresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                aw_stall  = 1'b0;
                w_beat    = 0;
                w_burst   = aw_log.size();
                b_pending = 0;
                lvl       = 0;
                ack_s     = 1'b0;
                ack_b     = 1'b0;
            end else begin
                ack_s = bus.s_valid && bus.s_ready;
                ack_b = bus.m_bvalid && bus.m_bready;
                if (bus.m_awvalid) awv_cycles++;
                if (busy) busy_cycles++;
                if (aw_stall) begin
                    chk("aw_stable",
                        {bus.m_awvalid, bus.m_awlen, bus.m_awaddr},
                        {1'b1, st_len, st_addr});
                end else if (bus.m_awvalid) begin
                    chk("aw_level", lvl >= int'(bus.m_awlen) + 1, 1);
                end
                if (bus.m_wvalid && bus.m_wready) begin
                    w_total++;
                    lvl--;
                    chk("w_after_aw", w_burst < aw_log.size(), 1);
                    if (w_burst < aw_log.size()) begin
                        e = aw_log[w_burst];
                        a = e[39:8] + 32'(w_beat * 8);
                        mem[a] = bus.m_wdata;
                        chk("wlast", bus.m_wlast, w_beat == int'(e[7:0]));
                        if (w_beat == int'(e[7:0])) begin
                            w_burst++;
                            w_beat = 0;
                            b_pending++;
                        end else begin
                            w_beat++;
                        end
                    end
                end
                if (bus.m_awvalid && bus.m_awready) begin
                    aw_log.push_back({bus.m_awaddr, bus.m_awlen});
                    aw_stall = 1'b0;
                end else begin
                    aw_stall = bus.m_awvalid;
                    st_addr  = bus.m_awaddr;
                    st_len   = bus.m_awlen;
                end
                if (ack_s) begin
                    acc_total++;
                    lvl++;
                end
                if (ack_b) last_b_cyc = cyc + 1;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
            @(posedge clk);
            cyc++;
            #1;
            if (!bus.s_valid || ack_s) begin
                if (int'($urandom_range(99)) < p_sv) begin
                    wd = {$urandom, $urandom};
                    bus.s_valid = 1'b1;
                    bus.s_data  = wd;
                    gen_q.push_back(wd);
                end else begin
                    bus.s_valid = 1'b0;
                end
            end
            if (ack_b || !rstn) bus.m_bvalid = 1'b0;
            if (rstn && !bus.m_bvalid && b_pending > 0 &&
                int'($urandom_range(99)) < p_b) begin
                bus.m_bvalid = 1'b1;
                bus.m_bresp  = (b_issue == err_b_idx) ? 2'b10 : 2'b00;
                b_issue++;
                b_pending--;
            end
            bus.m_awready = int'($urandom_range(99)) < p_aw;
            bus.m_wready  = int'($urandom_range(99)) < p_w;
        end
    end

    task automatic pulse_start(input logic [31:0] b, input int t);
        @(posedge clk);
        #1;
        base_addr   = b;
        total_beats = 24'(t);
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_xfer(input logic [31:0] base, input int total,
                            input int pv, input int pa, input int pw,
                            input int pb, input int err_rel,
                            input bit restart);
        int aw0, acc0, d0, n, nb, rem, len;
        logic [31:0] a;
        p_sv = pv;
        p_aw = pa;
        p_w  = pw;
        p_b  = pb;
        aw0  = aw_log.size();
        acc0 = acc_total;
        d0   = done_cnt;
        err_b_idx = (err_rel < 0) ? -1 : b_issue + err_rel;
        pulse_start(base, total);
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        chk("err_cleared", err, 0);
        n = 0;
        while (done_cnt == d0 && n < 5000) begin
            @(posedge clk);
            #1;
            if (restart && n == 8) begin
                base_addr   = base + 32'h0008_0000;
                total_beats = 24'd5;
                start       = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        chk("done_timeout", n < 5000, 1);
        repeat (4) @(negedge clk);
        #1;
        chk("done_once", done_cnt - d0, 1);
        chk("done_latency", done_cyc, last_b_cyc);
        chk("busy_end", busy, 0);
        chk("err_end", err, err_rel >= 0);
        chk("accepted", acc_total - acc0, total);
        a   = base;
        rem = total;
        nb  = 0;
        while (rem > 0) begin
            len = (rem > 16) ? 16 : rem;
            if (aw0 + nb < aw_log.size()) begin
                chk("aw_burst", aw_log[aw0 + nb], {a, 8'(len - 1)});
            end
            a   = a + 32'(len * 8);
            rem = rem - len;
            nb++;
        end
        chk("aw_count", aw_log.size() - aw0, nb);
        for (int i = 0; i < total; i++) begin
            a = base + 32'(i * 8);
            if (acc0 + i < gen_q.size()) begin
                chk("mem_data", mem.exists(a) ? mem[a] : 64'hx,
                    gen_q[acc0 + i]);
            end
        end
    endtask

    initial begin : main
        int d0, av0, bz0, w0, n;
        rstn        = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        total_beats = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("reset_ctrl",
            {bus.s_ready, bus.m_awvalid, bus.m_wvalid, bus.m_wlast,
             bus.m_bready, busy, done, err}, 0);
        chk("reset_aw", {bus.m_awaddr, bus.m_awlen}, 0);
        chk("reset_wdata", bus.m_wdata, 0);
        chk("const_out", {bus.m_awsize, bus.m_awburst, bus.m_wstrb},
            {3'd3, 2'b01, 8'hFF});

        run_xfer(32'h1000_0000, 32, 100, 100, 100, 100, -1, 1'b0);
        run_xfer(32'h1000_4000, 20, 100, 100, 100, 100, -1, 1'b0);
        run_xfer(32'h1001_0000, 100, 70, 60, 70, 50, -1, 1'b0);
        run_xfer(32'h1002_0000, 48, 80, 70, 80, 60, 1, 1'b0);
        run_xfer(32'h1003_0000, 40, 75, 65, 75, 55, -1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            run_xfer(32'h1100_0000 + 32'(k) * 32'h0001_0000,
                     int'($urandom_range(70, 1)), 70, 60, 70, 60, -1, 1'b0);
        end

        d0  = done_cnt;
        av0 = awv_cycles;
        bz0 = busy_cycles;
        pulse_start(32'h1004_0000, 0);
        @(negedge clk);
        chk("zero_done", {done, busy}, 2'b10);
        @(negedge clk);
        chk("zero_done_pulse", done, 0);
        repeat (5) @(negedge clk);
        #1;
        chk("zero_no_aw", awv_cycles - av0, 0);
        chk("zero_no_busy", busy_cycles - bz0, 0);
        chk("zero_done_once", done_cnt - d0, 1);

        p_sv = 100;
        p_aw = 100;
        p_w  = 100;
        p_b  = 100;
        err_b_idx = -1;
        w0 = w_total;
        pulse_start(32'h2000_0000, 48);
        n = 0;
        while (w_total - w0 < 5 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reset_reached_burst", w_total - w0 >= 5, 1);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_reset_ctrl",
            {bus.s_ready, bus.m_awvalid, bus.m_wvalid, bus.m_wlast,
             bus.m_bready, busy, done, err}, 0);
        chk("async_reset_aw", {bus.m_awaddr, bus.m_awlen}, 0);
        chk("async_reset_wdata", bus.m_wdata, 0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        run_xfer(32'h3000_0000, 16, 80, 70, 70, 60, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
